// File: rtl/sobel_strip_sequencer_pkg.sv
// Shared constants and FSM encoding for the Sobel strip sequencer.
// Each strip needs NUM_ACC+BORDER_COLS input bytes, and a strip holds at least MIN_ROWS rows.
package sobel_strip_sequencer_pkg;

  localparam int NUM_SOBEL_ACCELERATORS = 8;
  localparam int BORDER_COLS            = 2;
  localparam int MIN_ROWS               = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_NEXT  = 3'd4,
    S_FIN   = 3'd5
  } state_e;

endpackage

// File: rtl/sobel_addr_gen.sv
// Strip column (c0) and row-base tracking plus the read/write byte address adders.
// Row offsets are built one image row at a time, so no multiplier is needed.
module sobel_addr_gen #(
  parameter int NUM_ACC = 8,
  parameter int ADDR_W  = 32,
  parameter int DIM_W   = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic              next_row_i,
  input  logic              next_strip_i,
  input  logic [DIM_W-1:0]  cols_i,
  input  logic [DIM_W-1:0]  last_c0_i,
  input  logic [ADDR_W-1:0] src_base_i,
  input  logic [ADDR_W-1:0] dst_base_i,
  output logic              at_last_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [ADDR_W-1:0] wr_addr_o
);

  localparam logic [DIM_W:0]    STEP     = NUM_ACC[DIM_W:0];
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [DIM_W-1:0]  c0_q, c0_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [DIM_W:0]    c0_step;
  logic [ADDR_W-1:0] cols_ext, c0_ext;

  assign cols_ext = {{(ADDR_W-DIM_W){1'b0}}, cols_i};
  assign c0_ext   = {{(ADDR_W-DIM_W){1'b0}}, c0_q};
  assign c0_step  = {1'b0, c0_q} + STEP;

  always_comb begin
    c0_d       = c0_q;
    row_base_d = row_base_q;
    if (clear_i) begin
      c0_d       = '0;
      row_base_d = '0;
    end else if (next_strip_i) begin
      // The last strip is pulled back to end exactly at the right border.
      row_base_d = '0;
      c0_d       = (c0_step >= {1'b0, last_c0_i}) ? last_c0_i : c0_step[DIM_W-1:0];
    end else if (next_row_i) begin
      row_base_d = row_base_q + cols_ext;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      c0_q       <= '0;
      row_base_q <= '0;
    end else begin
      c0_q       <= c0_d;
      row_base_q <= row_base_d;
    end
  end

  assign at_last_o = (c0_q == last_c0_i);
  assign rd_addr_o = src_base_i + row_base_q + c0_ext;
  // row_base is already one past the newest row, so the centre row sits two rows back.
  assign wr_addr_o = dst_base_i + row_base_q - (cols_ext << 1) + c0_ext + ADDR_ONE;

endmodule

// File: rtl/sobel_strip_sequencer.sv
// Walks the image strip by strip: primes three row registers, then alternates one
// read (row shift) and one result-row write until the strip's last row is consumed.
module sobel_strip_sequencer
  import sobel_strip_sequencer_pkg::*;
#(
  parameter int NUM_ACC = NUM_SOBEL_ACCELERATORS,
  parameter int ADDR_W  = 32,
  parameter int DIM_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [DIM_W-1:0]  img_cols,
  input  logic [DIM_W-1:0]  img_rows,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  output logic              row_shift,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_ack,
  output state_e            dbg_state_o
);

  localparam int             MIN_COLS_I = NUM_ACC + BORDER_COLS;
  localparam logic [DIM_W:0] MIN_COLS   = MIN_COLS_I[DIM_W:0];
  localparam logic [DIM_W:0] MIN_ROWS_W = MIN_ROWS[DIM_W:0];

  state_e            state_q, state_d;
  logic [DIM_W-1:0]  cols_q, rows_q, row_q, row_d;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [1:0]        prime_q, prime_d;
  logic              accept_go;
  logic              ag_clear, ag_next_row, ag_next_strip, at_last;
  logic [DIM_W-1:0]  last_c0;
  logic [ADDR_W-1:0] ag_rd_addr, ag_wr_addr;

  assign last_c0 = cols_q - MIN_COLS[DIM_W-1:0];

  sobel_addr_gen #(
    .NUM_ACC (NUM_ACC),
    .ADDR_W  (ADDR_W),
    .DIM_W   (DIM_W)
  ) u_addr_gen (
    .clk_i        (clk),
    .reset_i      (reset),
    .clear_i      (ag_clear),
    .next_row_i   (ag_next_row),
    .next_strip_i (ag_next_strip),
    .cols_i       (cols_q),
    .last_c0_i    (last_c0),
    .src_base_i   (src_q),
    .dst_base_i   (dst_q),
    .at_last_o    (at_last),
    .rd_addr_o    (ag_rd_addr),
    .wr_addr_o    (ag_wr_addr)
  );

  // Handshakes: rd_req/wr_en rise with a stable address and stay high until the
  // matching ack is seen on a rising edge; an ack with no request is ignored.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    prime_d       = prime_q;
    accept_go     = 1'b0;
    ag_clear      = 1'b0;
    ag_next_row   = 1'b0;
    ag_next_strip = 1'b0;
    rd_req        = 1'b0;
    wr_en         = 1'b0;
    done          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          accept_go = 1'b1;
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (({1'b0, cols_q} < MIN_COLS) || ({1'b0, rows_q} < MIN_ROWS_W)) begin
          state_d = S_FIN;
        end else begin
          ag_clear = 1'b1;
          row_d    = '0;
          prime_d  = '0;
          state_d  = S_READ;
        end
      end
      S_READ: begin
        rd_req = 1'b1;
        if (rd_ack) begin
          ag_next_row = 1'b1;
          row_d       = row_q + 1'b1;
          if (prime_q < 2'd2) prime_d = prime_q + 2'd1;
          else                state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        wr_en = 1'b1;
        if (wr_ack) state_d = (row_q < rows_q) ? S_READ : S_NEXT;
      end
      S_NEXT: begin
        if (at_last) begin
          state_d = S_FIN;
        end else begin
          ag_next_strip = 1'b1;
          row_d         = '0;
          prime_d       = '0;
          state_d       = S_READ;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      prime_q <= '0;
      cols_q  <= '0;
      rows_q  <= '0;
      src_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      prime_q <= prime_d;
      if (accept_go) begin
        cols_q <= img_cols;
        rows_q <= img_rows;
        src_q  <= src_base;
        dst_q  <= dst_base;
      end
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign row_shift   = rd_req & rd_ack;
  assign rd_addr     = rd_req ? ag_rd_addr : '0;
  assign wr_addr     = wr_en  ? ag_wr_addr : '0;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sobel_strip_sequencer.sv
// Directed bench for the strip sequencer with NUM_ACC=4: address scoreboard,
// handshake-rule monitor and hand-computed completion latencies.
module tb_sobel_strip_sequencer;
  import sobel_strip_sequencer_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int DIM_W   = 16;
  localparam int NUM_ACC = 4;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              go = 1'b0;
  logic [DIM_W-1:0]  img_cols = '0;
  logic [DIM_W-1:0]  img_rows = '0;
  logic [ADDR_W-1:0] src_base = '0;
  logic [ADDR_W-1:0] dst_base = '0;
  logic              rd_ack = 1'b0;
  logic              wr_ack = 1'b0;
  logic              busy, done, rd_req, row_shift, wr_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  state_e            dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sobel_strip_sequencer #(
    .NUM_ACC (NUM_ACC),
    .ADDR_W  (ADDR_W),
    .DIM_W   (DIM_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .img_cols    (img_cols),
    .img_rows    (img_rows),
    .src_base    (src_base),
    .dst_base    (dst_base),
    .busy        (busy),
    .done        (done),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_ack      (rd_ack),
    .row_shift   (row_shift),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_ack      (wr_ack),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [ADDR_W-1:0] exp_rd_q[$];
  logic [ADDR_W-1:0] exp_wr_q[$];
  int rd_cyc_q[$];
  int n_rd, n_wr, n_shift, n_rdreq, n_wren, n_done, n_extra, n_viol;
  int done_cyc, go_cyc;
  bit done_prev, rd_pend, wr_pend;
  logic [ADDR_W-1:0] rd_prev_addr, wr_prev_addr;

  // memory responder controls
  int rd_wait, wr_wait, rd_stall_after, rd_stall_len, wr_stall_after, wr_stall_len;
  bit rd_armed, wr_armed, spurious;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic clear_sb();
    exp_rd_q.delete();
    exp_wr_q.delete();
    rd_cyc_q.delete();
    n_rd = 0; n_wr = 0; n_shift = 0; n_rdreq = 0; n_wren = 0;
    n_done = 0; n_extra = 0; n_viol = 0; done_cyc = 0; go_cyc = 0;
    rd_wait = 0; wr_wait = 0; rd_armed = 0; wr_armed = 0; spurious = 0;
  endtask

  // ---------------- memory responder ----------------
  always @(negedge clk) begin
    if (rd_req) begin
      if (rd_armed && n_rd == rd_stall_after) begin
        rd_wait  = rd_stall_len;
        rd_armed = 0;
      end
      if (rd_wait > 0) begin rd_ack = 1'b0; rd_wait--; end
      else rd_ack = 1'b1;
    end else begin
      rd_ack = spurious;
    end
    if (wr_en) begin
      if (wr_armed && n_wr == wr_stall_after) begin
        wr_wait  = wr_stall_len;
        wr_armed = 0;
      end
      if (wr_wait > 0) begin wr_ack = 1'b0; wr_wait--; end
      else wr_ack = 1'b1;
    end else begin
      wr_ack = spurious;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    #1;
    if (reset) begin
      rd_pend   = 0;
      wr_pend   = 0;
      done_prev = 0;
    end else begin
      if (rd_req && wr_en) n_viol++;
      if (row_shift !== (rd_req && rd_ack)) n_viol++;
      if (rd_pend && (!rd_req || rd_addr !== rd_prev_addr)) n_viol++;
      if (wr_pend && (!wr_en || wr_addr !== wr_prev_addr)) n_viol++;
      if (rd_req) n_rdreq++;
      if (wr_en) n_wren++;
      if (row_shift) n_shift++;
      if (rd_req && rd_ack) begin
        n_rd++;
        rd_cyc_q.push_back(cyc);
        if (exp_rd_q.size() > 0) check_eq("rd_addr", rd_addr, exp_rd_q.pop_front());
        else n_extra++;
      end
      if (wr_en && wr_ack) begin
        n_wr++;
        if (exp_wr_q.size() > 0) check_eq("wr_addr", wr_addr, exp_wr_q.pop_front());
        else n_extra++;
      end
      if (done) begin
        if (done_prev) n_viol++;
        else begin n_done++; done_cyc = cyc; end
      end
      done_prev    = done;
      rd_pend      = rd_req && !rd_ack;
      wr_pend      = wr_en && !wr_ack;
      rd_prev_addr = rd_addr;
      wr_prev_addr = wr_addr;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_img(input int cols, input int rows, input logic [31:0] src, input logic [31:0] dst);
    @(negedge clk);
    img_cols = cols[DIM_W-1:0];
    img_rows = rows[DIM_W-1:0];
    src_base = src;
    dst_base = dst;
    go       = 1'b1;
    go_cyc   = cyc;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      @(negedge clk);
      #2;
      k++;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ctrl"}, {busy, done, rd_req, wr_en, row_shift}, 0);
    check_eq({tag, "_rd_addr"}, rd_addr, 0);
    check_eq({tag, "_wr_addr"}, wr_addr, 0);
    check_eq({tag, "_state"}, dbg_state, S_IDLE);
  endtask

  task automatic check_totals(input string tag, input int reads, input int writes, input int latency);
    repeat (3) @(negedge clk);
    #2;
    check_eq({tag, "_reads"}, n_rd, reads);
    check_eq({tag, "_writes"}, n_wr, writes);
    check_eq({tag, "_shifts"}, n_shift, reads);
    check_eq({tag, "_done_pulses"}, n_done, 1);
    check_eq({tag, "_latency"}, done_cyc - go_cyc, latency);
    check_eq({tag, "_rd_left"}, exp_rd_q.size(), 0);
    check_eq({tag, "_wr_left"}, exp_wr_q.size(), 0);
    check_eq({tag, "_extra"}, n_extra, 0);
    check_eq({tag, "_protocol"}, n_viol, 0);
    check_eq({tag, "_idle_busy"}, busy, 0);
  endtask

  task automatic load_s2(input logic [31:0] src, input logic [31:0] dst);
    int rd_off[12] = '{0, 11, 22, 33, 4, 15, 26, 37, 5, 16, 27, 38};
    int wr_off[6]  = '{12, 23, 16, 27, 17, 28};
    foreach (rd_off[i]) exp_rd_q.push_back(src + rd_off[i]);
    foreach (wr_off[i]) exp_wr_q.push_back(dst + wr_off[i]);
  endtask

  task automatic run_s1(input string tag);
    clear_sb();
    exp_rd_q.push_back(32'h100);
    exp_rd_q.push_back(32'h106);
    exp_rd_q.push_back(32'h10C);
    exp_wr_q.push_back(32'h207);
    start_img(6, 3, 32'h100, 32'h200);
    #1;
    check_eq({tag, "_busy_after_go"}, busy, 1);
    check_eq({tag, "_state_check"}, dbg_state, S_CHECK);
    wait_done(100);
    @(negedge clk);
    #2;
    check_eq({tag, "_busy_drop"}, busy, 0);
    if (rd_cyc_q.size() == 3)
      check_eq({tag, "_rd_back_to_back"}, rd_cyc_q[2] - rd_cyc_q[0], 2);
    check_totals(tag, 3, 1, 7);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    clear_sb();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;

    // minimal accepted image
    run_s1("s1");

    // three overlapping strips
    clear_sb();
    load_s2(32'h1000, 32'h2000);
    start_img(11, 4, 32'h1000, 32'h2000);
    wait_done(200);
    check_totals("s2", 12, 6, 23);

    // stalled second read, stalled first write, stray acks while idle on that port
    clear_sb();
    load_s2(32'h1000, 32'h2000);
    rd_stall_after = 1; rd_stall_len = 5; rd_armed = 1;
    wr_stall_after = 0; wr_stall_len = 3; wr_armed = 1;
    spurious = 1;
    start_img(11, 4, 32'h1000, 32'h2000);
    wait_done(300);
    check_totals("s3", 12, 6, 31);
    spurious = 0;

    // too narrow, then too short
    clear_sb();
    start_img(5, 10, 32'h100, 32'h200);
    wait_done(20);
    repeat (3) @(negedge clk);
    check_eq("s4a_latency", done_cyc - go_cyc, 2);
    check_eq("s4a_done_pulses", n_done, 1);
    check_eq("s4a_rd_req", n_rdreq, 0);
    check_eq("s4a_wr_en", n_wren, 0);
    clear_sb();
    start_img(20, 2, 32'h100, 32'h200);
    wait_done(20);
    repeat (3) @(negedge clk);
    check_eq("s4b_latency", done_cyc - go_cyc, 2);
    check_eq("s4b_done_pulses", n_done, 1);
    check_eq("s4b_rd_req", n_rdreq, 0);
    check_eq("s4b_wr_en", n_wren, 0);

    // reset while writing in the second strip
    clear_sb();
    load_s2(32'h1000, 32'h2000);
    start_img(11, 4, 32'h1000, 32'h2000);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #2;
      if (n_wr >= 2 && wr_en) break;
    end
    check_eq("s5_in_write", dbg_state, S_WRITE);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("s5_abort");
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    check_eq("s5_no_done", n_done, 0);
    check_eq("s5_stays_idle", busy, 0);
    run_s1("s5_rerun");

    // go re-pulsed with other dimensions while busy
    clear_sb();
    exp_rd_q.push_back(32'h100);
    exp_rd_q.push_back(32'h106);
    exp_rd_q.push_back(32'h10C);
    exp_wr_q.push_back(32'h207);
    start_img(6, 3, 32'h100, 32'h200);
    img_cols = 16'd11;
    img_rows = 16'd4;
    src_base = 32'h5000;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_done(100);
    check_totals("s6a", 3, 1, 7);

    // go coincident with reset
    clear_sb();
    @(negedge clk);
    img_cols = 16'd6;
    img_rows = 16'd3;
    src_base = 32'h100;
    dst_base = 32'h200;
    reset = 1'b1;
    go = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    go = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    check_eq("s6b_busy", busy, 0);
    check_eq("s6b_rd_req", n_rdreq, 0);
    check_eq("s6b_done", n_done, 0);
    run_s1("s6b_rerun");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
